// File: rtl/dsp_pkg.sv
// Shared DSP helpers: constant-width utilities used by the accumulate/cast datapath.
package dsp_pkg;

    localparam int MAX_ACC_WIDTH = 64;

    // Wide all-ones constant; modules slice off the low DOUT_WIDTH bits they need.
    localparam logic [MAX_ACC_WIDTH-1:0] ACC_ONES = '1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/unsign_sat_add.sv
// Unsigned saturating adder: zero-extends a into the S_WIDTH domain and clamps on carry-out.
module unsign_sat_add
    import dsp_pkg::*;
#(
    parameter int A_WIDTH = 16,
    parameter int S_WIDTH = 32
) (
    input  logic [S_WIDTH-1:0] s,
    input  logic [A_WIDTH-1:0] a,
    output logic [S_WIDTH-1:0] y,
    output logic               ovf
);

    logic [S_WIDTH:0] sum_w;

    always_comb begin
        sum_w = {1'b0, s} + (S_WIDTH+1)'(a);
        ovf   = sum_w[S_WIDTH];
        y     = ovf ? ACC_ONES[S_WIDTH-1:0] : sum_w[S_WIDTH-1:0];
    end

endmodule

// File: rtl/unsign_acc_dump.sv
// Integrate-and-dump accumulator: sums acc_len valid samples and emits one saturating wide sum per frame.
module unsign_acc_dump
    import dsp_pkg::*;
#(
    parameter int DIN_WIDTH  = 16,
    parameter int DOUT_WIDTH = 32,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIN_WIDTH-1:0]  din,
    input  logic                  din_valid,
    input  logic [LEN_WIDTH-1:0]  acc_len,
    input  logic                  sync,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  dout_sat,
    output logic                  busy
);

    logic [DOUT_WIDTH-1:0] acc;
    logic [DOUT_WIDTH-1:0] acc_base;
    logic [DOUT_WIDTH-1:0] sum;
    logic [LEN_WIDTH-1:0]  cnt;
    logic [LEN_WIDTH-1:0]  cnt_base;
    logic [LEN_WIDTH-1:0]  len_r;
    logic [LEN_WIDTH-1:0]  len_cur;
    logic [LEN_WIDTH:0]    len_eff;
    logic [LEN_WIDTH:0]    cnt_next;
    logic                  sat_r;
    logic                  sat_base;
    logic                  ovf;
    logic                  frame_start;
    logic                  last;

    // sync discards the partial frame, so the current sample sees a clean accumulator.
    always_comb begin
        frame_start = sync || (cnt == '0);
        acc_base    = sync ? '0 : acc;
        cnt_base    = sync ? '0 : cnt;
        sat_base    = sync ? 1'b0 : sat_r;
        len_cur     = frame_start ? acc_len : len_r;
        len_eff     = (len_cur == '0) ? (LEN_WIDTH+1)'(1) : {1'b0, len_cur};
        cnt_next    = {1'b0, cnt_base} + (LEN_WIDTH+1)'(1);
        last        = (cnt_next == len_eff);
    end

    // One adder serves both the running sum and the final dump sum.
    unsign_sat_add #(
        .A_WIDTH(DIN_WIDTH),
        .S_WIDTH(DOUT_WIDTH)
    ) u_sat_add (
        .s  (acc_base),
        .a  (din),
        .y  (sum),
        .ovf(ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            cnt        <= '0;
            len_r      <= '0;
            sat_r      <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_sat   <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (din_valid) begin
                if (frame_start) len_r <= acc_len;
                if (last) begin
                    dout       <= sum;
                    dout_sat   <= sat_base | ovf;
                    dout_valid <= 1'b1;
                    acc        <= '0;
                    cnt        <= '0;
                    sat_r      <= 1'b0;
                end else begin
                    acc   <= sum;
                    cnt   <= cnt_next[LEN_WIDTH-1:0];
                    sat_r <= sat_base | ovf;
                end
            end else if (sync) begin
                acc   <= '0;
                cnt   <= '0;
                sat_r <= 1'b0;
            end
        end
    end

    assign busy = (cnt != '0);

endmodule
